color_matrix_pipe: RTL and testbench
====================================

// Module: color_matrix_pipe
// PURPOSE
//  Pipelined 3x3 colour-space matrix (e.g. RGB->YCbCr, colour correction) with runtime-loadable coefficients.
//  Adds per-channel offsets, round-half-up and saturation.
//  Coefficient updates are double-buffered and take effect only at a frame boundary.
//  Sits after the demosaic/filter stages in the processing chain.
// PARAMETERS
//  width     320               pixels per line
//  height    240               lines per frame
//  frameSize width*height      pixels per frame (oDone period)
//  IN_W      8                 unsigned input channel width
//  COEF_W    18                signed coefficient width
//  FRAC      17                coefficient fractional bits
//  OUT_W     18                signed output width (OUT_W <= COEF_W)
//  OUT_FRAC  9                 output fractional bits (OUT_FRAC < FRAC)
// PORTS
//  clk          in   1        clock
//  reset        in   1        synchronous, active-high reset
//  iValid       in   1        input pixel valid
//  iX,iY,iZ     in   IN_W     unsigned input channels
//  iCoefWe      in   1        write shadow coefficient bank
//  iCoefAddr    in   4        0..8 = m00,m01,m02,m10..m22 (row-major); 9..11 = offA,offB,offC; 12..15 ignored
//  iCoefData    in   COEF_W   write data; offsets use bits [OUT_W-1:0], in output format
//  iCoefApply   in   1        1-cycle request to copy shadow->active bank
//  oA,oB,oC     out  OUT_W    signed results, OUT_FRAC fractional bits
//  oValid       out  1        output valid
//  oDone        out  1        pulses with oValid of the last pixel of a frame
//  oCoefPending out  1        apply requested, not yet performed
// BEHAVIOUR
//  Reset:
//   - all outputs 0; pipeline valids, pixel counters and pending cleared.
//   - active and shadow banks = identity (diag = 1<<FRAC, others 0, offsets 0).
//   - reset mid-frame discards in-flight pixels; next accepted pixel is pixel 0.
//  Pipeline: fixed 4-cycle latency, no stalls; iValid at cycle t -> oValid at t+4.
//   S1: register inputs.
//   S2: nine products (zero-extended in) x (active coef), IN_W+1+COEF_W bits.
//   S3: row sums + (offset <<< (FRAC-OUT_FRAC)) + (1 << (FRAC-OUT_FRAC-1)).
//   S4: arithmetic >>> (FRAC-OUT_FRAC), saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1], register.
//  Counters:
//   - input counter increments per accepted pixel, wraps frameSize-1 -> 0.
//   - output counter does the same on oValid; oDone=1 the cycle it is at frameSize-1.
//  Coefficient bank:
//   - iCoefWe writes shadow at any time, 1-cycle effect.
//   - iCoefApply sets pending; apply while pending is absorbed.
//   - Transfer shadow->active occurs on first cycle with pending=1, input counter=0, iValid=0 and S1 valid=0;
//     pending clears the next cycle.
//   - Write and transfer in the same cycle: transfer copies the pre-write shadow value.
//   - Back-to-back frames with no idle gap: transfer deferred; pending remains high.
//   - Every pixel of a frame uses one coefficient set.
// TESTING
//  T1 identity: after reset, X,Y,Z=200,100,50 -> 4 cycles later oA=102400, oB=51200, oC=25600, oValid=1.
//  T2 rgb2ycc: load {39164,76926,14982; -22138,-43398,65536; 65536,-54906,-10630}, offsets 0, apply while idle;
//     input 255,255,255 -> oA=130560, oB=0, oC=0.
//  T3 saturation: row A all 131071, input 255s -> oA=131071; row A all -131072 -> oA=-131072.
//  T4 rounding: m00=1 (raw), others 0, X=128 -> oA=1; X=127 -> oA=0; offA=-1, X=0 -> oA=-1.
//  T5 frame/apply (width=4, height=2):
//     - stream 8 pixels -> oDone only with the 8th oValid.
//     - apply at pixel 3: pixels 3..7 use the old bank; oCoefPending=1 until 2 idle cycles after the frame.
//     - with no gap before the next frame, pending stays 1 throughout.
//  T6 reset mid-frame: after 3 pixels assert reset 1 cycle -> oValid=0 next cycle, banks = identity;
//     next 8 pixels -> oDone on the 8th.

Source files
------------

// File: rtl/color_matrix_pipe.sv
// 3x3 colour matrix, four register stages: input, products, row sums with offset/rounding, shift/saturate.
// Coefficients are double-buffered; the shadow bank reaches the active bank only between frames.
module color_matrix_pipe #(
    parameter int width     = 320,
    parameter int height    = 240,
    parameter int frameSize = width * height,
    parameter int IN_W      = 8,
    parameter int COEF_W    = 18,
    parameter int FRAC      = 17,
    parameter int OUT_W     = 18,
    parameter int OUT_FRAC  = 9
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    iValid,
    input  logic [IN_W-1:0]         iX,
    input  logic [IN_W-1:0]         iY,
    input  logic [IN_W-1:0]         iZ,
    input  logic                    iCoefWe,
    input  logic [3:0]              iCoefAddr,
    input  logic [COEF_W-1:0]       iCoefData,
    input  logic                    iCoefApply,
    output logic signed [OUT_W-1:0] oA,
    output logic signed [OUT_W-1:0] oB,
    output logic signed [OUT_W-1:0] oC,
    output logic                    oValid,
    output logic                    oDone,
    output logic                    oCoefPending
);
    localparam int SH     = FRAC - OUT_FRAC;
    // One extra bank bit so the reset identity (+1.0) is representable; loaded values are sign-extended.
    localparam int BANK_W = COEF_W + 1;
    localparam int PROD_W = IN_W + 1 + COEF_W;
    localparam int SUM_W  = PROD_W + 2;
    localparam int CNT_W  = (frameSize > 1) ? $clog2(frameSize) : 1;

    localparam logic [CNT_W-1:0]         LAST_PIX = CNT_W'(frameSize - 1);
    localparam logic signed [BANK_W-1:0] COEF_ONE = BANK_W'(1'b1) << FRAC;
    localparam logic signed [SUM_W-1:0]  ROUND_C  = SUM_W'(1'b1) << (SH - 1);
    localparam logic signed [OUT_W-1:0]  SAT_MAX  = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0]  SAT_MIN  = {1'b1, {(OUT_W-1){1'b0}}};

    function automatic logic signed [OUT_W-1:0] shift_sat(input logic signed [SUM_W-1:0] sum);
        logic signed [SUM_W-1:0] shifted;
        logic [SUM_W-OUT_W:0]    top;
        shifted = sum >>> SH;
        top     = shifted[SUM_W-1:OUT_W-1];
        if ((&top) || !(|top)) begin
            shift_sat = shifted[OUT_W-1:0];
        end else if (top[SUM_W-OUT_W]) begin
            shift_sat = SAT_MIN;
        end else begin
            shift_sat = SAT_MAX;
        end
    endfunction

    function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] cnt);
        if (cnt == LAST_PIX) begin
            next_cnt = '0;
        end else begin
            next_cnt = cnt + CNT_W'(1'b1);
        end
    endfunction

    logic signed [BANK_W-1:0] r_sh_m    [9];
    logic signed [OUT_W-1:0]  r_sh_off  [3];
    logic signed [BANK_W-1:0] r_act_m   [9];
    logic signed [OUT_W-1:0]  r_act_off [3];
    logic                     r_pending;
    logic [CNT_W-1:0]         r_in_cnt;
    logic [CNT_W-1:0]         r_out_cnt;

    logic                     r_s1_valid;
    logic [IN_W-1:0]          r_s1_px   [3];
    logic                     r_s2_valid;
    logic signed [PROD_W-1:0] r_s2_prod [9];
    logic                     r_s3_valid;
    logic signed [SUM_W-1:0]  r_s3_sum  [3];

    logic                     w_transfer;
    logic [1:0]               w_off_idx;
    logic signed [PROD_W-1:0] w_prod    [9];
    logic signed [SUM_W-1:0]  w_sum     [3];

    // Promotion waits for a frame boundary with nothing queued in front of the product stage.
    assign w_transfer   = r_pending && (r_in_cnt == '0) && !iValid && !r_s1_valid;
    assign w_off_idx    = 2'(iCoefAddr - 4'd9);
    assign oCoefPending = r_pending;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 9; k++) begin
                r_sh_m[k] <= ((k % 4) == 0) ? COEF_ONE : '0;
            end
            for (int k = 0; k < 3; k++) begin
                r_sh_off[k] <= '0;
            end
        end else if (iCoefWe) begin
            if (iCoefAddr < 4'd9) begin
                r_sh_m[iCoefAddr] <= BANK_W'($signed(iCoefData));
            end else if (iCoefAddr < 4'd12) begin
                r_sh_off[w_off_idx] <= $signed(iCoefData[OUT_W-1:0]);
            end
        end
    end

    // Active bank copies the pre-write shadow contents when a write lands on the transfer cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 9; k++) begin
                r_act_m[k] <= ((k % 4) == 0) ? COEF_ONE : '0;
            end
            for (int k = 0; k < 3; k++) begin
                r_act_off[k] <= '0;
            end
        end else if (w_transfer) begin
            for (int k = 0; k < 9; k++) begin
                r_act_m[k] <= r_sh_m[k];
            end
            for (int k = 0; k < 3; k++) begin
                r_act_off[k] <= r_sh_off[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= 1'b0;
        end else if (w_transfer) begin
            r_pending <= 1'b0;
        end else if (iCoefApply) begin
            r_pending <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
        end else begin
            if (iValid) begin
                r_in_cnt <= next_cnt(r_in_cnt);
            end
            if (r_s3_valid) begin
                r_out_cnt <= next_cnt(r_out_cnt);
            end
        end
    end

    // Product k = row (k/3) coefficient times input channel (k%3); inputs are zero-extended to signed.
    always_comb begin
        for (int k = 0; k < 9; k++) begin
            w_prod[k] = $signed(PROD_W'(r_s1_px[k % 3])) * PROD_W'(r_act_m[k]);
        end
        for (int r = 0; r < 3; r++) begin
            w_sum[r] = SUM_W'(r_s2_prod[3*r]) + SUM_W'(r_s2_prod[3*r+1]) + SUM_W'(r_s2_prod[3*r+2])
                     + (SUM_W'(r_act_off[r]) <<< SH) + ROUND_C;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s3_valid <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                r_s1_px[k]  <= '0;
                r_s3_sum[k] <= '0;
            end
            for (int k = 0; k < 9; k++) begin
                r_s2_prod[k] <= '0;
            end
        end else begin
            r_s1_valid <= iValid;
            r_s1_px[0] <= iX;
            r_s1_px[1] <= iY;
            r_s1_px[2] <= iZ;
            r_s2_valid <= r_s1_valid;
            for (int k = 0; k < 9; k++) begin
                r_s2_prod[k] <= w_prod[k];
            end
            r_s3_valid <= r_s2_valid;
            for (int k = 0; k < 3; k++) begin
                r_s3_sum[k] <= w_sum[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            oA     <= '0;
            oB     <= '0;
            oC     <= '0;
            oValid <= 1'b0;
            oDone  <= 1'b0;
        end else begin
            oA     <= shift_sat(r_s3_sum[0]);
            oB     <= shift_sat(r_s3_sum[1]);
            oC     <= shift_sat(r_s3_sum[2]);
            oValid <= r_s3_valid;
            oDone  <= r_s3_valid && (r_out_cnt == LAST_PIX);
        end
    end

endmodule

// File: tb/tb_color_matrix_pipe.sv
// Directed bench for color_matrix_pipe on a 4x2 frame: vector table plus frame/apply/reset sequences.
module tb_color_matrix_pipe;
    logic               clk = 1'b0;
    logic               reset;
    logic               iValid;
    logic [7:0]         iX, iY, iZ;
    logic               iCoefWe;
    logic [3:0]         iCoefAddr;
    logic [17:0]        iCoefData;
    logic               iCoefApply;
    logic signed [17:0] oA, oB, oC;
    logic               oValid, oDone, oCoefPending;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int cfg;
        int x;
        int y;
        int z;
        int ea;
        int eb;
        int ec;
    } vec_t;

    vec_t vt [13];

    always #5 clk = ~clk;

    color_matrix_pipe #(.width(4), .height(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .iValid       (iValid),
        .iX           (iX),
        .iY           (iY),
        .iZ           (iZ),
        .iCoefWe      (iCoefWe),
        .iCoefAddr    (iCoefAddr),
        .iCoefData    (iCoefData),
        .iCoefApply   (iCoefApply),
        .oA           (oA),
        .oB           (oB),
        .oC           (oC),
        .oValid       (oValid),
        .oDone        (oDone),
        .oCoefPending (oCoefPending)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic wr(input int addr, input int val);
        iCoefWe   = 1'b1;
        iCoefAddr = 4'(addr);
        iCoefData = 18'(val);
        tick();
        iCoefWe   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic apply_idle(input string name);
        iCoefApply = 1'b1;
        tick();
        iCoefApply = 1'b0;
        chk({name, "_pend_set"}, int'(oCoefPending), 1);
        for (int k = 0; k < 8 && oCoefPending; k++) tick();
        chk({name, "_pend_clr"}, int'(oCoefPending), 0);
    endtask

    task automatic pix_check(input string nm, input int x, input int y, input int z,
                             input int ea, input int eb, input int ec);
        iX = 8'(x); iY = 8'(y); iZ = 8'(z);
        iValid = 1'b1;
        tick();
        iValid = 1'b0;
        tick();
        tick();
        chk({nm, "_early"}, int'(oValid), 0);
        tick();
        chk({nm, "_valid"}, int'(oValid), 1);
        chk({nm, "_A"}, int'(oA), ea);
        chk({nm, "_B"}, int'(oB), eb);
        chk({nm, "_C"}, int'(oC), ec);
    endtask

    task automatic load_cfg(input int cfg);
        do_reset();
        case (cfg)
            1: begin
                wr(0, 39164);  wr(1, 76926);  wr(2, 14982);
                wr(3, -22138); wr(4, -43398); wr(5, 65536);
                wr(6, 65536);  wr(7, -54906); wr(8, -10630);
            end
            2: for (int a = 0; a < 3; a++) wr(a, 131071);
            3: for (int a = 0; a < 3; a++) wr(a, -131072);
            4, 5: begin
                wr(0, 1);
                for (int a = 1; a < 9; a++) wr(a, 0);
                if (cfg == 5) wr(9, -1);
            end
            default: ;
        endcase
        if (cfg != 0) apply_idle($sformatf("cfg%0d", cfg));
    endtask

    initial begin
        int prev;
        reset = 1'b1; iValid = 1'b0; iX = 8'd0; iY = 8'd0; iZ = 8'd0;
        iCoefWe = 1'b0; iCoefAddr = 4'd0; iCoefData = 18'd0; iCoefApply = 1'b0;

        vt[0]  = '{0, 200, 100, 50, 102400, 51200, 25600};
        vt[1]  = '{0, 255, 0, 1, 130560, 0, 512};
        vt[2]  = '{0, 0, 0, 0, 0, 0, 0};
        vt[3]  = '{1, 255, 255, 255, 130560, 0, 0};
        vt[4]  = '{1, 255, 0, 0, 39011, -22052, 65280};
        vt[5]  = '{2, 255, 255, 255, 131071, 130560, 130560};
        vt[6]  = '{2, 1, 0, 0, 512, 0, 0};
        vt[7]  = '{3, 255, 255, 255, -131072, 130560, 130560};
        vt[8]  = '{3, 1, 0, 0, -512, 0, 0};
        vt[9]  = '{4, 128, 0, 0, 1, 0, 0};
        vt[10] = '{4, 127, 0, 0, 0, 0, 0};
        vt[11] = '{5, 0, 0, 0, -1, 0, 0};
        vt[12] = '{5, 128, 0, 0, 0, 0, 0};

        tick();
        tick();
        reset = 1'b0;
        chk("rst_A", int'(oA), 0);
        chk("rst_B", int'(oB), 0);
        chk("rst_C", int'(oC), 0);
        chk("rst_valid", int'(oValid), 0);
        chk("rst_done", int'(oDone), 0);
        chk("rst_pend", int'(oCoefPending), 0);

        prev = -1;
        for (int i = 0; i < 13; i++) begin
            if (vt[i].cfg != prev) load_cfg(vt[i].cfg);
            prev = vt[i].cfg;
            pix_check($sformatf("vec%0d", i), vt[i].x, vt[i].y, vt[i].z, vt[i].ea, vt[i].eb, vt[i].ec);
        end

        // One frame, apply mid-frame: old bank throughout, promotion two idle cycles after the frame.
        do_reset();
        wr(0, 65536);
        for (int c = 0; c < 13; c++) begin
            if (c >= 4 && c <= 11) begin
                chk("t5_valid", int'(oValid), 1);
                chk("t5_A", int'(oA), 102400);
                chk("t5_done", int'(oDone), int'(c == 11));
            end else begin
                chk("t5_idle", int'(oValid), 0);
            end
            chk("t5_pend", int'(oCoefPending), int'(c >= 4 && c <= 9));
            iValid = (c < 8); iX = 8'd200; iY = 8'd100; iZ = 8'd50;
            iCoefApply = (c == 3);
            tick();
        end
        iValid = 1'b0;
        iCoefApply = 1'b0;

        // Two frames back to back: transfer deferred across the boundary.
        wr(0, 32768);
        for (int c = 0; c < 21; c++) begin
            if (c >= 4 && c <= 19) begin
                chk("b2b_valid", int'(oValid), 1);
                chk("b2b_A", int'(oA), 51200);
                chk("b2b_done", int'(oDone), int'(c == 11 || c == 19));
            end else begin
                chk("b2b_idle", int'(oValid), 0);
            end
            chk("b2b_pend", int'(oCoefPending), int'(c >= 3 && c <= 17));
            iValid = (c < 16); iX = 8'd200; iY = 8'd100; iZ = 8'd50;
            iCoefApply = (c == 2);
            tick();
        end
        iValid = 1'b0;
        iCoefApply = 1'b0;
        pix_check("b2b_newbank", 200, 100, 50, 25600, 51200, 25600);

        // Reset mid-frame discards in-flight pixels and restores identity in both banks.
        do_reset();
        wr(0, 32768);
        apply_idle("t6_pre");
        for (int c = 0; c < 17; c++) begin
            if (c == 4) begin
                chk("t6_rst_valid", int'(oValid), 0);
                chk("t6_rst_A", int'(oA), 0);
                chk("t6_rst_pend", int'(oCoefPending), 0);
            end
            if (c >= 8 && c <= 15) begin
                chk("t6_valid", int'(oValid), 1);
                chk("t6_A", int'(oA), 102400);
                chk("t6_done", int'(oDone), int'(c == 15));
            end else begin
                chk("t6_idle", int'(oValid), 0);
            end
            reset  = (c == 3);
            iValid = (c < 3) || (c >= 4 && c <= 11);
            iX = 8'd200; iY = 8'd100; iZ = 8'd50;
            tick();
        end
        reset = 1'b0;
        iValid = 1'b0;
        apply_idle("t6_post");
        pix_check("t6_shadow_id", 200, 100, 50, 102400, 51200, 25600);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
